// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_pkg
//  Purpose  : Shared definitions for the PC update unit: FSM state encoding,
//             exception cause codes, default vector-table base and a helper
//             that folds the reserved cause onto the opcode cause.
//  Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Exception sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_LOAD = 2'd3;

    typedef enum logic [1:0] {
        CAUSE_OPCODE   = 2'd0,
        CAUSE_OVERFLOW = 2'd1,
        CAUSE_DIV_ZERO = 2'd2,
        CAUSE_RSVD     = 2'd3
    } cause_e;

    localparam int VEC_BASE_DEFAULT = 253;

    // The reserved cause code has no vector entry of its own; it shares the
    // illegal-opcode handler.
    function automatic logic [1:0] normalize_cause(input logic [1:0] cause);
        return (cause == CAUSE_RSVD) ? CAUSE_OPCODE : cause;
    endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_update_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_update_unit_if
//  Purpose  : Bundles the control, datapath and memory signals of the PC
//             update unit. The "slave" modport is the unit itself; the
//             "master" modport is the surrounding core (control unit, ALU,
//             memory).
//  Ports    : src_data/src_sel      - flat-packed next-PC sources and index
//             pc_write/pc_write_c   - unconditional / conditional PC load
//             cond_true             - branch condition
//             exc_req/exc_cause     - exception pulse and cause code
//             eret                  - exception return pulse
//             mem_rdata             - vector byte returned from memory
//             mem_req/mem_addr      - vector read strobe and address
//             pc/epc                - architectural PC and exception PC
//             busy/exc_done         - sequence in progress / handler loaded
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_update_unit_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         src_sel;
    logic                     pc_write;
    logic                     pc_write_c;
    logic                     cond_true;
    logic                     exc_req;
    logic [1:0]               exc_cause;
    logic                     eret;
    logic [7:0]               mem_rdata;
    logic                     mem_req;
    logic [WIDTH-1:0]         mem_addr;
    logic [WIDTH-1:0]         pc;
    logic [WIDTH-1:0]         epc;
    logic                     busy;
    logic                     exc_done;

    modport slave (
        input  src_data, src_sel, pc_write, pc_write_c, cond_true,
               exc_req, exc_cause, eret, mem_rdata,
        output mem_req, mem_addr, pc, epc, busy, exc_done
    );

    modport master (
        output src_data, src_sel, pc_write, pc_write_c, cond_true,
               exc_req, exc_cause, eret, mem_rdata,
        input  mem_req, mem_addr, pc, epc, busy, exc_done
    );

endinterface : pc_update_unit_if
`default_nettype wire

// File: rtl/pc_src_mux.sv
`default_nettype none
// ============================================================================
//  Module   : pc_src_mux
//  Purpose  : Combinational NUM_SRC x WIDTH selector for the next PC. Flags
//             indices that do not name a real source so the caller can
//             suppress the load.
//  Ports    : src_data     in  flat-packed sources, source i at [i*WIDTH +: WIDTH]
//             src_sel      in  source index
//             sel_data     out selected source (zero when out of range)
//             out_of_range out src_sel >= NUM_SRC
//  Revision : 1.0 - initial release
// ============================================================================
module pc_src_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  wire logic [NUM_SRC*WIDTH-1:0] src_data,
    input  wire logic [SEL_W-1:0]         src_sel,
    output logic      [WIDTH-1:0]         sel_data,
    output logic                          out_of_range
);

    logic [WIDTH-1:0] w_src [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_split
        assign w_src[gi] = src_data[gi*WIDTH +: WIDTH];
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                sel_data = w_src[i];
            end
        end
    end

    assign out_of_range = ({{(32-SEL_W){1'b0}}, src_sel} >= 32'(NUM_SRC));

endmodule : pc_src_mux
`default_nettype wire

// File: rtl/pc_update_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_update_unit
//  Purpose  : Owns PC and EPC of the multi-cycle core. Loads the next PC from
//             one of NUM_SRC sources, sequences exception entry (save EPC,
//             fetch handler byte from the vector table, load PC) and handles
//             exception return (EPC -> PC).
//  Ports    : clk   in  rising-edge clock
//             reset in  synchronous active-high reset
//             bus   --  pc_update_unit_if.slave (see interface header)
//  Revision : 1.0 - initial release
// ============================================================================
module pc_update_unit
    import pc_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int          NUM_SRC  = 4,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned VEC_BASE = VEC_BASE_DEFAULT,
    parameter int          MEM_LAT  = 2,
    parameter int unsigned PC_ADJ   = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pc_update_unit_if.slave   bus
);

    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [1:0]       r_cause;
    logic             r_vec_valid;   // a vector address has been issued since reset

    logic [WIDTH-1:0] w_sel_data;
    logic             w_out_of_range;
    logic             w_pc_load;

    pc_src_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .src_data     (bus.src_data),
        .src_sel      (bus.src_sel),
        .sel_data     (w_sel_data),
        .out_of_range (w_out_of_range)
    );

    assign w_pc_load = (bus.pc_write | (bus.pc_write_c & bus.cond_true)) & ~w_out_of_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pc        <= WIDTH'(RESET_PC);
            r_epc       <= '0;
            r_cause     <= 2'd0;
            r_vec_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Exception outranks eret and any PC write in the same cycle.
                    if (bus.exc_req) begin
                        r_cause     <= normalize_cause(bus.exc_cause);
                        r_epc       <= r_pc - WIDTH'(PC_ADJ);
                        r_vec_valid <= 1'b1;
                        r_state     <= ST_REQ;
                    end else if (bus.eret) begin
                        r_pc <= r_epc;
                    end else if (w_pc_load) begin
                        r_pc <= w_sel_data;
                    end
                end
                ST_REQ: begin
                    if (MEM_LAT == 1) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_cnt   <= CNT_W'(MEM_LAT - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Leave when the count reaches zero so LOAD lands exactly
                    // MEM_LAT cycles after the request cycle.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_pc    <= {{(WIDTH-8){1'b0}}, bus.mem_rdata};
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Address is derived from the latched cause; it reads zero until the
    // first exception after reset and then holds between sequences.
    assign bus.mem_addr = r_vec_valid ? (WIDTH'(VEC_BASE) + WIDTH'(r_cause)) : '0;
    assign bus.mem_req  = (r_state == ST_REQ);
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.exc_done = (r_state == ST_LOAD);
    assign bus.pc       = r_pc;
    assign bus.epc      = r_epc;

endmodule : pc_update_unit
`default_nettype wire

// File: tb/tb_pc_update_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_update_unit
//  Purpose  : Self-checking bench for pc_update_unit: directed scenarios then
//             randomized traffic against a cycle-count reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_update_unit;

    localparam int WIDTH    = 32;
    localparam int NUM_SRC  = 3;
    localparam int MEM_LAT  = 2;
    localparam int VEC_BASE = 253;
    localparam int PC_ADJ   = 4;
    localparam int LOAD_K   = MEM_LAT + 1;  // cycles after acceptance at which the handler loads

    logic clk = 1'b0;
    logic reset;

    pc_update_unit_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC)) bus ();

    pc_update_unit #(
        .WIDTH    (WIDTH),
        .NUM_SRC  (NUM_SRC),
        .RESET_PC (0),
        .VEC_BASE (VEC_BASE),
        .MEM_LAT  (MEM_LAT),
        .PC_ADJ   (PC_ADJ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: k counts cycles since an exception was accepted
    // (0 = no sequence). k==1 is the request cycle, k==LOAD_K the load cycle.
    logic [31:0] m_pc, m_epc, m_addr;
    int          m_k;
    logic [7:0]  handler;
    logic [31:0] src [NUM_SRC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.pc_write   = 1'b0;
        bus.pc_write_c = 1'b0;
        bus.cond_true  = 1'b0;
        bus.exc_req    = 1'b0;
        bus.exc_cause  = 2'd0;
        bus.eret       = 1'b0;
    endtask

    task automatic cycle();
        int sel;
        for (int i = 0; i < NUM_SRC; i++) bus.src_data[i*WIDTH +: WIDTH] = src[i];
        bus.mem_rdata = (m_k == LOAD_K) ? handler : 8'($urandom);
        sel = int'(bus.src_sel);
        if (reset) begin
            m_pc = 0; m_epc = 0; m_addr = 0; m_k = 0;
        end else if (m_k == 0) begin
            if (bus.exc_req) begin
                m_epc  = m_pc - PC_ADJ;
                m_addr = VEC_BASE + ((bus.exc_cause == 2'd3) ? 0 : int'(bus.exc_cause));
                m_k    = 1;
            end else if (bus.eret) begin
                m_pc = m_epc;
            end else if ((bus.pc_write || (bus.pc_write_c && bus.cond_true)) && sel < NUM_SRC) begin
                m_pc = src[sel];
            end
        end else if (m_k == LOAD_K) begin
            m_pc = {24'd0, bus.mem_rdata};
            m_k  = 0;
        end else begin
            m_k++;
        end
        @(posedge clk);
        #1;
        check("pc",       bus.pc,       m_pc);
        check("epc",      bus.epc,      m_epc);
        check("mem_addr", bus.mem_addr, m_addr);
        check("busy",     32'(bus.busy),     32'(m_k != 0));
        check("mem_req",  32'(bus.mem_req),  32'(m_k == 1));
        check("exc_done", 32'(bus.exc_done), 32'(m_k == LOAD_K));
    endtask

    // Run the current sequence to completion, poking ignored controls each cycle.
    task automatic drain(input logic poke);
        int n = 0;
        while (m_k != 0 && n < 20) begin
            idle_inputs();
            if (poke) begin
                bus.pc_write = 1'b1;
                bus.exc_req  = 1'b1;
                bus.eret     = 1'b1;
                bus.src_sel  = 2'd0;
            end
            cycle();
            n++;
        end
        check("drain_bound", 32'(m_k), 32'd0);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        bus.src_sel = '0;
        bus.mem_rdata = '0;
        handler = 8'h00;
        m_pc = 'x; m_epc = 'x; m_addr = 'x; m_k = 0;
        for (int i = 0; i < NUM_SRC; i++) src[i] = $urandom;

        // Reset state
        cycle();
        cycle();
        reset = 1'b0;

        // Unconditional write from source 2
        src[2] = 32'h0040_0010; src[1] = 32'h0000_0100;
        bus.pc_write = 1'b1; bus.src_sel = 2'd2;
        cycle();
        check("pc_write_src2", bus.pc, 32'h0040_0010);
        bus.pc_write = 1'b0;

        // Conditional write: not taken, then taken
        bus.pc_write_c = 1'b1; bus.cond_true = 1'b0; bus.src_sel = 2'd1;
        cycle();
        bus.cond_true = 1'b1;
        cycle();
        check("branch_taken", bus.pc, 32'h0000_0100);
        idle_inputs();

        // Out-of-range source index: pc holds
        bus.pc_write = 1'b1; bus.src_sel = 2'd3;
        cycle();
        check("oor_hold", bus.pc, 32'h0000_0100);

        // pc = 0x24, then exception (cause 1) together with a PC write
        src[0] = 32'h24; bus.src_sel = 2'd0;
        cycle();
        src[0] = 32'hDEAD_BEEF;
        bus.exc_req = 1'b1; bus.exc_cause = 2'd1;
        handler = 8'h7C;
        cycle();
        check("epc_saved", bus.epc, 32'h20);
        drain(1'b1);
        check("handler_pc", bus.pc, 32'h7C);

        // Exception return
        bus.eret = 1'b1;
        cycle();
        check("eret_pc", bus.pc, 32'h20);
        idle_inputs();

        // pc = 0, reserved cause -> EPC wraps, vector for cause 0
        src[0] = 32'h0; bus.pc_write = 1'b1; bus.src_sel = 2'd0;
        cycle();
        idle_inputs();
        bus.exc_req = 1'b1; bus.exc_cause = 2'd3; handler = 8'hA5;
        cycle();
        check("epc_wrap", bus.epc, 32'hFFFF_FFFC);
        check("vec_cause3", bus.mem_addr, 32'd253);
        drain(1'b0);

        // Reset while waiting for the vector byte
        bus.exc_req = 1'b1; bus.exc_cause = 2'd2; handler = 8'h11;
        cycle();
        idle_inputs();
        cycle();
        reset = 1'b1;
        cycle();
        check("reset_mid_pc", bus.pc, 32'h0);
        reset = 1'b0;
        cycle();

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < NUM_SRC; i++) src[i] = $urandom;
            reset          = ($urandom_range(0, 59) == 0);
            bus.exc_req    = ($urandom_range(0, 7) == 0);
            bus.exc_cause  = 2'($urandom);
            bus.eret       = ($urandom_range(0, 9) == 0);
            bus.pc_write   = ($urandom_range(0, 2) == 0);
            bus.pc_write_c = ($urandom_range(0, 2) == 0);
            bus.cond_true  = 1'($urandom);
            bus.src_sel    = 2'($urandom);
            handler        = 8'($urandom);
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_update_unit
`default_nettype wire
